// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control path: sequencer states,
// decoded instruction classes, opcode/ext field values and mux selects.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_FAULT  = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        CL_ALU_R = 3'd0,
        CL_ALU_I = 3'd1,
        CL_LOAD  = 3'd2,
        CL_STOR  = 3'd3,
        CL_BCOND = 3'd4,
        CL_JCOND = 3'd5,
        CL_JAL   = 3'd6,
        CL_HALT  = 3'd7
    } instr_class_e;

    localparam logic [3:0] OP_ALU_R  = 4'b0000;
    localparam logic [3:0] OP_EXT    = 4'b0100;
    localparam logic [3:0] OP_BCOND  = 4'b1100;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JCOND = 4'b1100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;

    localparam logic [1:0] PC_SEL_INC  = 2'd0;
    localparam logic [1:0] PC_SEL_DISP = 2'd1;
    localparam logic [1:0] PC_SEL_REG  = 2'd2;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_MEM  = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;

endpackage

// File: rtl/instr_seq_ctrl_if.sv
// Signal bundle between the sequencer and the memory interface, IR, PC mux
// and register-file write port. The sequencer side is the master.
interface instr_seq_ctrl_if;

    logic        run;
    logic        mem_ready;
    logic [15:0] ir;
    logic        flag_cond;

    logic        ir_wen;
    logic        pc_en;
    logic [1:0]  pc_sel;
    logic        mem_ren;
    logic        mem_wen;
    logic        addr_sel;
    logic        rf_wen;
    logic [1:0]  wb_sel;
    logic        halted;
    logic        fault;
    logic [15:0] instr_count;
    logic [2:0]  state_dbg;

    modport master (
        input  run, mem_ready, ir, flag_cond,
        output ir_wen, pc_en, pc_sel, mem_ren, mem_wen, addr_sel,
               rf_wen, wb_sel, halted, fault, instr_count, state_dbg
    );

    modport slave (
        output run, mem_ready, ir, flag_cond,
        input  ir_wen, pc_en, pc_sel, mem_ren, mem_wen, addr_sel,
               rf_wen, wb_sel, halted, fault, instr_count, state_dbg
    );

endinterface

// File: rtl/instr_class_dec.sv
// Combinational instruction classifier from the opcode and ext fields of the
// IR; shared by the sequencer and the condition evaluator.
module instr_class_dec
    import cpu_ctrl_pkg::*;
#(
    parameter logic [3:0] HALT_OP = 4'b1110
) (
    input  logic [3:0]   op_i,
    input  logic [3:0]   ext_i,
    output instr_class_e class_o
);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        class_o = CL_ALU_I;
        if (op_i == HALT_OP) begin
            class_o = CL_HALT;
        end else if (op_i == OP_ALU_R) begin
            class_o = CL_ALU_R;
        end else if (op_i == OP_EXT) begin
            case (ext_i)
                EXT_LOAD:  class_o = CL_LOAD;
                EXT_STOR:  class_o = CL_STOR;
                EXT_JCOND: class_o = CL_JCOND;
                EXT_JAL:   class_o = CL_JAL;
                default:   class_o = CL_ALU_R;
            endcase
        end else if (op_i == OP_BCOND) begin
            class_o = CL_BCOND;
        end
    end

endmodule

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the 16-bit
// CPU; sole driver of the IR, PC, memory-strobe and register-file enables.
module instr_seq_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter logic [3:0]  HALT_OP      = 4'b1110
) (
    input  logic             clk,
    input  logic             reset,
    instr_seq_ctrl_if.master bus
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

    state_e       state_q, state_d;
    logic [7:0]   wait_q, wait_d;
    logic [15:0]  count_q;
    instr_class_e iclass;

    logic        ir_wen, pc_en, mem_ren, mem_wen, addr_sel, rf_wen, halted, fault;
    logic [1:0]  pc_sel, wb_sel;
    logic        waiting, timeout;
    logic [7:0]  wait_inc;

    instr_class_dec #(
        .HALT_OP (HALT_OP)
    ) u_class_dec (
        .op_i    (bus.ir[15:12]),
        .ext_i   (bus.ir[7:4]),
        .class_o (iclass)
    );

    assign waiting  = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign wait_inc = wait_q + 8'd1;
    // A ready in the limit cycle completes the access instead of faulting.
    assign timeout  = !bus.mem_ready && (wait_inc == WAIT_LIMIT);
    assign wait_d   = (waiting && !bus.mem_ready) ? wait_inc : 8'd0;

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            wait_q  <= 8'd0;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_q + 16'(pc_en);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.run) state_d = ST_FETCH;
            ST_FETCH: begin
                if (bus.mem_ready) state_d = ST_DECODE;
                else if (timeout)  state_d = ST_FAULT;
            end
            ST_DECODE: begin
                case (iclass)
                    CL_HALT:          state_d = ST_HALT;
                    CL_LOAD, CL_STOR: state_d = ST_MEM;
                    default:          state_d = ST_EXEC;
                endcase
            end
            ST_EXEC:   state_d = ST_FETCH;
            ST_MEM: begin
                if (bus.mem_ready) state_d = (iclass == CL_LOAD) ? ST_WB : ST_FETCH;
                else if (timeout)  state_d = ST_FAULT;
            end
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ir_wen   = 1'b0;
        pc_en    = 1'b0;
        pc_sel   = PC_SEL_INC;
        mem_ren  = 1'b0;
        mem_wen  = 1'b0;
        addr_sel = 1'b0;
        rf_wen   = 1'b0;
        wb_sel   = WB_SEL_ALU;
        halted   = 1'b0;
        fault    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_ren = 1'b1;
                ir_wen  = bus.mem_ready;
            end
            ST_EXEC: begin
                pc_en = 1'b1;
                case (iclass)
                    CL_ALU_R, CL_ALU_I: rf_wen = 1'b1;
                    CL_BCOND: pc_sel = bus.flag_cond ? PC_SEL_DISP : PC_SEL_INC;
                    CL_JCOND: pc_sel = bus.flag_cond ? PC_SEL_REG : PC_SEL_INC;
                    CL_JAL: begin
                        rf_wen = 1'b1;
                        wb_sel = WB_SEL_LINK;
                        pc_sel = PC_SEL_REG;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                addr_sel = 1'b1;
                mem_ren  = (iclass == CL_LOAD);
                mem_wen  = (iclass == CL_STOR);
                pc_en    = bus.mem_ready && (iclass == CL_STOR);
            end
            ST_WB: begin
                rf_wen = 1'b1;
                wb_sel = WB_SEL_MEM;
                pc_en  = 1'b1;
            end
            ST_HALT:  halted = 1'b1;
            ST_FAULT: fault  = 1'b1;
            default: ;
        endcase
    end

    assign bus.ir_wen      = ir_wen;
    assign bus.pc_en       = pc_en;
    assign bus.pc_sel      = pc_sel;
    assign bus.mem_ren     = mem_ren;
    assign bus.mem_wen     = mem_wen;
    assign bus.addr_sel    = addr_sel;
    assign bus.rf_wen      = rf_wen;
    assign bus.wb_sel      = wb_sel;
    assign bus.halted      = halted;
    assign bus.fault       = fault;
    assign bus.instr_count = count_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Directed bench for instr_seq_ctrl: inputs change on the falling edge and
// outputs are compared 1 ns later, with hand-computed expected vectors.
module tb_instr_seq_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
    localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_FAULT = 3'd7;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    instr_seq_ctrl_if bus ();

    instr_seq_ctrl #(
        .MEM_WAIT_MAX (15),
        .HALT_OP      (4'b1110)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    function automatic logic [15:0] obs();
        return {bus.ir_wen, bus.pc_en, bus.pc_sel, bus.mem_ren, bus.mem_wen, bus.addr_sel,
                bus.rf_wen, bus.wb_sel, bus.halted, bus.fault, 1'b0, bus.state_dbg};
    endfunction

    function automatic logic [15:0] mk(input logic irw, input logic pce, input logic [1:0] pcs,
                                       input logic mr, input logic mw, input logic as,
                                       input logic rfw, input logic [1:0] wbs,
                                       input logic hlt, input logic flt, input logic [2:0] st);
        return {irw, pce, pcs, mr, mw, as, rfw, wbs, hlt, flt, 1'b0, st};
    endfunction

    task automatic cyc(input logic rdy, input logic fc);
        @(negedge clk);
        bus.mem_ready = rdy;
        bus.flag_cond = fc;
        #1;
    endtask

    // FETCH with `waits` ready-low cycles, the ready cycle loading `instr`, then DECODE.
    task automatic fetch_instr(input logic [15:0] instr, input int waits, input string name);
        logic [15:0] e;
        for (int i = 0; i < waits; i++) begin
            cyc(1'b0, 1'b0);
            bus.run = 1'b0;
            e = mk(0, 0, 2'd0, 1, 0, 0, 0, 2'd0, 0, 0, S_FETCH);
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL %s_fetch_wait%0d: got %h want %h", name, i, obs(), e);
            end
        end
        cyc(1'b1, 1'b0);
        bus.run = 1'b0;
        bus.ir  = instr;
        e = mk(1, 0, 2'd0, 1, 0, 0, 0, 2'd0, 0, 0, S_FETCH);
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL %s_fetch_ready: got %h want %h", name, obs(), e);
        end
        cyc(1'b0, 1'b0);
        e = mk(0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, S_DECODE);
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL %s_decode: got %h want %h", name, obs(), e);
        end
    endtask

    task automatic exec_step(input logic fc, input logic [15:0] e, input string name);
        cyc(1'b0, fc);
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL %s_exec: got %h want %h", name, obs(), e);
        end
    endtask

    task automatic check_count(input logic [15:0] want, input string name);
        n_checks++;
        if (bus.instr_count !== want) begin
            n_fail++;
            $display("FAIL %s_count: got %h want %h", name, bus.instr_count, want);
        end
    endtask

    task automatic test_reset();
        bus.run = 1'b0; bus.mem_ready = 1'b0; bus.ir = 16'h0000; bus.flag_cond = 1'b0;
        #12;
        n_checks++;
        if (obs() !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_outs: got %h want %h", obs(), 16'h0000);
        end
        check_count(16'd0, "reset");
        @(negedge clk);
        reset = 1'b1;
        cyc(1'b0, 1'b0);
        n_checks++;
        if (obs() !== 16'h0000) begin
            n_fail++;
            $display("FAIL idle_no_run: got %h want %h", obs(), 16'h0000);
        end
    endtask

    task automatic test_alu();
        @(negedge clk);
        bus.run = 1'b1;
        #1;
        fetch_instr(16'h0123, 2, "alu");
        exec_step(1'b0, mk(0, 1, 2'd0, 0, 0, 0, 1, 2'd0, 0, 0, S_EXEC), "alu");
        @(posedge clk); #1;
        check_count(16'd1, "alu");
    endtask

    task automatic test_load();
        logic [15:0] e;
        fetch_instr(16'h4A05, 0, "load");
        cyc(1'b1, 1'b0);
        e = mk(0, 0, 2'd0, 1, 0, 1, 0, 2'd0, 0, 0, S_MEM);
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL load_mem: got %h want %h", obs(), e);
        end
        cyc(1'b0, 1'b0);
        e = mk(0, 1, 2'd0, 0, 0, 0, 1, 2'd1, 0, 0, S_WB);
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL load_wb: got %h want %h", obs(), e);
        end
        @(posedge clk); #1;
        check_count(16'd2, "load");
    endtask

    task automatic test_branch_jump();
        fetch_instr(16'hC312, 0, "bcond_t");
        exec_step(1'b1, mk(0, 1, 2'd1, 0, 0, 0, 0, 2'd0, 0, 0, S_EXEC), "bcond_t");
        fetch_instr(16'hC312, 0, "bcond_n");
        exec_step(1'b0, mk(0, 1, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, S_EXEC), "bcond_n");
        fetch_instr(16'h408E, 0, "jal");
        exec_step(1'b0, mk(0, 1, 2'd2, 0, 0, 0, 1, 2'd2, 0, 0, S_EXEC), "jal");
        fetch_instr(16'h40C0, 0, "jcond_t");
        exec_step(1'b1, mk(0, 1, 2'd2, 0, 0, 0, 0, 2'd0, 0, 0, S_EXEC), "jcond_t");
        fetch_instr(16'h1234, 0, "alu_i");
        exec_step(1'b0, mk(0, 1, 2'd0, 0, 0, 0, 1, 2'd0, 0, 0, S_EXEC), "alu_i");
        fetch_instr(16'h4010, 0, "ext_other");
        exec_step(1'b0, mk(0, 1, 2'd0, 0, 0, 0, 1, 2'd0, 0, 0, S_EXEC), "ext_other");
        @(posedge clk); #1;
        check_count(16'd8, "branch");
    endtask

    task automatic test_store();
        logic [15:0] e;
        fetch_instr(16'h4040, 0, "stor");
        cyc(1'b0, 1'b0);
        e = mk(0, 0, 2'd0, 0, 1, 1, 0, 2'd0, 0, 0, S_MEM);
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL stor_mem_wait: got %h want %h", obs(), e);
        end
        cyc(1'b1, 1'b0);
        e = mk(0, 1, 2'd0, 0, 1, 1, 0, 2'd0, 0, 0, S_MEM);
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL stor_mem_ready: got %h want %h", obs(), e);
        end
        @(posedge clk); #1;
        check_count(16'd9, "stor");
    endtask

    task automatic test_reset_mid_stor();
        logic [15:0] e;
        fetch_instr(16'h4040, 0, "rst_stor");
        cyc(1'b0, 1'b0);
        e = mk(0, 0, 2'd0, 0, 1, 1, 0, 2'd0, 0, 0, S_MEM);
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL rst_stor_mem: got %h want %h", obs(), e);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (obs() !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_stor_async: got %h want %h", obs(), 16'h0000);
        end
        check_count(16'd0, "rst_stor");
        #1 reset = 1'b1;
    endtask

    task automatic test_fault();
        logic [15:0] e;
        @(negedge clk);
        bus.run = 1'b1;
        #1;
        for (int i = 1; i <= 15; i++) begin
            cyc(1'b0, 1'b0);
            bus.run = 1'b0;
            e = mk(0, 0, 2'd0, 1, 0, 0, 0, 2'd0, 0, 0, S_FETCH);
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL timeout_wait%0d: got %h want %h", i, obs(), e);
            end
        end
        e = mk(0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 1, S_FAULT);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0);
            bus.run = 1'b1;
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL fault_sticky%0d: got %h want %h", i, obs(), e);
            end
        end
        @(negedge clk);
        bus.run = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (obs() !== 16'h0000) begin
            n_fail++;
            $display("FAIL fault_cleared: got %h want %h", obs(), 16'h0000);
        end
        @(negedge clk);
        bus.run = 1'b1;
        #1;
        fetch_instr(16'h0000, 14, "ready15");
        exec_step(1'b0, mk(0, 1, 2'd0, 0, 0, 0, 1, 2'd0, 0, 0, S_EXEC), "ready15");
    endtask

    task automatic test_halt();
        logic [15:0] e;
        @(posedge clk); #1;
        check_count(16'd1, "pre_halt");
        fetch_instr(16'hE000, 1, "halt");
        e = mk(0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 1, 0, S_HALT);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0);
            bus.run = 1'b1;
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL halt_hold%0d: got %h want %h", i, obs(), e);
            end
            check_count(16'd1, "halt");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_branch_jump();
        test_store();
        test_reset_mid_stor();
        test_fault();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
